fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  RESET_PC, 32'h0000_0000, first fetch address after reset.
  EPOCH_W, 2, width of the fetch epoch tag.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  bpu_next_pc  in  32  predicted next PC.
  bpu_jump  in  1  prediction is taken.
  exe_mispredict  in  1  EXE redirect request (highest priority).
  exe_redirect_pc  in  32  EXE redirect target.
  dc_mispredict  in  1  DC redirect request.
  dc_redirect_pc  in  32  DC redirect target.
  stall  in  1  backend stall.
  IM_ready  in  1  fetch buffer can accept a new IM response.
  fetch_pc  out  32  address driven to IM this cycle.
  fetch_req  out  1  fetch_pc is a valid request.
  fetch_jump  out  1  prediction tag for fetch_pc.
  fetch_epoch  out  EPOCH_W  epoch tag for fetch_pc.
  kill  out  1  discard the IM response that returns this cycle.
  redirect_cnt  out  32  redirect event counter (feature-gated).
  hold_cnt  out  32  hold-cycle counter (feature-gated).

Function
REQ-003 The FSM SHALL have states BOOT, RUN, HOLD and FLUSH, and SHALL enter BOOT on reset.
REQ-004 In BOOT, outputs SHALL be fetch_req=0 and fetch_pc=RESET_PC, and the next state SHALL be RUN unconditionally after 1 cycle.
REQ-005 fetch_pc SHALL be driven from the registered pc_q; fetch_req SHALL be 1 in RUN and FLUSH, and 0 in BOOT and HOLD.
REQ-006 Redirect priority SHALL be exe_mispredict > dc_mispredict > BPU; the two redirect requests SHALL be ignored in BOOT.
REQ-007 On a redirect in cycle N:
  pc_q SHALL take the winning target at N+1.
  fetch_epoch SHALL increment by 1 (mod 2^EPOCH_W) at N+1.
  The state SHALL be FLUSH at N+1, with kill=1 in that cycle only.
REQ-008 FLUSH SHALL last exactly 1 cycle, then go to RUN, or to HOLD if the hold condition is true.
REQ-009 The hold condition SHALL be stall OR !IM_ready.
  In RUN, a true hold condition with no redirect SHALL move the FSM to HOLD with pc_q unchanged.
  In HOLD, a false hold condition SHALL return the FSM to RUN.
REQ-010 A redirect in HOLD SHALL override the hold (REQ-007 applies): the target is captured and the FSM goes to FLUSH.
REQ-011 In RUN, with no hold and no redirect, pc_q SHALL load bpu_next_pc and fetch_jump SHALL register bpu_jump.
REQ-012 Simultaneous exe and dc redirects SHALL take the exe target and SHALL increment the epoch by 1 only.
REQ-013 Back-to-back redirects (N and N+1) SHALL each redirect and SHALL each produce kill at the following cycle.
REQ-014 PC arithmetic SHALL be 32-bit with no wrap detection; targets SHALL be used unmodified.

Reset
REQ-015 Reset SHALL be synchronous and active-high. Reset values SHALL be:
  state=BOOT, pc_q=RESET_PC, fetch_epoch=0, fetch_jump=0, kill=0, fetch_req=0, counters=0.
REQ-016 Reset asserted mid-operation SHALL override every other input in the same edge, including pending redirects.

Configuration
REQ-017 With FETCH_REDIRECT_PERF_EN defined, the counters SHALL behave as follows:
  redirect_cnt increments on each redirect cycle.
  hold_cnt increments on each HOLD cycle.
  Both saturate at 32'hFFFF_FFFF.
REQ-018 With FETCH_REDIRECT_PERF_EN undefined, both counters SHALL be tied to 0, no counter flops SHALL be generated, and all other behaviour SHALL be identical.

Structure
REQ-019 Package fetch_pkg SHALL hold the fetch_state_e enum (BOOT/RUN/HOLD/FLUSH), the redirect_src_e enum (NONE/DC/EXE) and the EPOCH_W default.
REQ-020 The counters SHALL be implemented in one sub-module, fetch_perf_counter (32-bit, saturating, enable input), instantiated twice under the macro.

Verification
REQ-021 Reset release: the bench SHALL check 1 cycle of fetch_req=0 with fetch_pc=0, then fetch_req=1 with fetch_pc=0 in RUN.
REQ-022 Redirect priority: exe_mispredict=1 (exe_redirect_pc=0x100) together with dc_mispredict=1 (dc_redirect_pc=0x200) -> next cycle fetch_pc=0x100, kill=1, epoch=1.
REQ-023 Hold: IM_ready=0 for 3 cycles with bpu_next_pc=0x40 -> fetch_pc holds for 3 cycles and fetch_req=0; the cycle after IM_ready=1 -> fetch_pc=0x40.
REQ-024 Redirect during hold: stall=1 plus dc_mispredict with target 0x80 -> next cycle FLUSH with fetch_pc=0x80 and kill=1.
REQ-025 Epoch wrap: 4 consecutive redirects -> epoch sequence 1, 2, 3, 0, with kill=1 in each following cycle.
REQ-026 Perf (macro defined): 5 redirects and 7 hold cycles -> redirect_cnt=5 and hold_cnt=7; with the macro undefined, both counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and defaults for the fetch redirect controller.
//   fetch_state_e  : controller FSM states (BOOT/RUN/HOLD/FLUSH)
//   redirect_src_e : which source won redirect arbitration this cycle
//   FETCH_EPOCH_W  : default width of the fetch epoch tag
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_EPOCH_W = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DC   = 2'd1,
        EXE  = 2'd2
    } redirect_src_e;

endpackage : fetch_pkg

// File: rtl/fetch_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the count
//   en_i    : count one event this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : fetch_perf_counter

// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
// Front-end fetch PC controller. Picks the next fetch address from the branch
// predictor, or from a DC/EXE mispredict redirect (EXE wins), stalls the
// fetch stream while the backend or fetch buffer cannot take more work, and
// tags every request with an epoch that advances on each redirect so stale
// responses can be recognised downstream.
//
// Optional feature: define FETCH_REDIRECT_PERF_EN to build the redirect and
// hold-cycle performance counters. Without it both counter outputs read 0.
//
// Ports:
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   bpu_next_pc/jump   : predicted next PC and its taken flag
//   exe_mispredict/pc  : EXE redirect request and target (highest priority)
//   dc_mispredict/pc   : DC redirect request and target
//   stall, IM_ready    : backend stall, fetch buffer ready
//   fetch_pc/req       : address presented to IM and its valid
//   fetch_jump/epoch   : prediction tag and epoch tag for fetch_pc
//   kill               : drop the IM response returning this cycle
//   redirect_cnt       : number of redirect cycles (perf build only)
//   hold_cnt           : number of HOLD cycles (perf build only)
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          EPOCH_W  = FETCH_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        bpu_next_pc,
    input  logic               bpu_jump,
    input  logic               exe_mispredict,
    input  logic [31:0]        exe_redirect_pc,
    input  logic               dc_mispredict,
    input  logic [31:0]        dc_redirect_pc,
    input  logic               stall,
    input  logic               IM_ready,
    output logic [31:0]        fetch_pc,
    output logic               fetch_req,
    output logic               fetch_jump,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               kill,
    output logic [31:0]        redirect_cnt,
    output logic [31:0]        hold_cnt
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               jump_q, jump_d;

    redirect_src_e      redirect_src;
    logic [31:0]        redirect_target;
    logic               redirect;
    logic               hold_cond;

    // Redirect arbitration. BOOT has not issued anything yet, so there is
    // nothing to redirect away from and both requests are ignored.
    always_comb begin
        redirect_src    = NONE;
        redirect_target = pc_q;
        if (state_q != BOOT) begin
            if (exe_mispredict) begin
                redirect_src    = EXE;
                redirect_target = exe_redirect_pc;
            end else if (dc_mispredict) begin
                redirect_src    = DC;
                redirect_target = dc_redirect_pc;
            end
        end
    end

    assign redirect  = (redirect_src != NONE);
    assign hold_cond = stall | ~IM_ready;

    // Next-state logic. RUN, HOLD and FLUSH share one rule set: a redirect
    // always wins, otherwise a hold parks the PC, otherwise the PC advances to
    // the prediction. Advancing out of HOLD therefore also takes the
    // prediction presented in the release cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        jump_d  = jump_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HOLD, FLUSH: begin
                if (redirect) begin
                    state_d = FLUSH;
                    pc_d    = redirect_target;
                    epoch_d = epoch_q + EPOCH_W'(1);
                    // A redirect target carries no prediction.
                    jump_d  = 1'b0;
                end else if (hold_cond) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    pc_d    = bpu_next_pc;
                    jump_d  = bpu_jump;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epoch_q <= '0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            jump_q  <= jump_d;
        end
    end

    // All outputs come straight from registered state. kill follows FLUSH so
    // back-to-back redirects keep killing for as long as FLUSH is re-entered.
    assign fetch_pc    = pc_q;
    assign fetch_req   = (state_q == RUN) || (state_q == FLUSH);
    assign fetch_jump  = jump_q;
    assign fetch_epoch = epoch_q;
    assign kill        = (state_q == FLUSH);

`ifdef FETCH_REDIRECT_PERF_EN
    fetch_perf_counter u_redirect_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (redirect),
        .count_o (redirect_cnt)
    );

    fetch_perf_counter u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q == HOLD),
        .count_o (hold_cnt)
    );
`else
    assign redirect_cnt = 32'd0;
    assign hold_cnt     = 32'd0;
`endif

endmodule : fetch_redirect_ctrl

// File: tb/tb_fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
// Self-checking bench for fetch_redirect_ctrl: a hand-computed vector table,
// hand-written corner sequences (epoch wrap, perf counters) and a randomized
// run checked against a behavioural model. Counter expectations follow the
// FETCH_REDIRECT_PERF_EN macro.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

`ifdef FETCH_REDIRECT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int EPOCH_MOD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bpu_next_pc;
    logic        bpu_jump;
    logic        exe_mispredict;
    logic [31:0] exe_redirect_pc;
    logic        dc_mispredict;
    logic [31:0] dc_redirect_pc;
    logic        stall;
    logic        IM_ready;
    logic [31:0] fetch_pc;
    logic        fetch_req;
    logic        fetch_jump;
    logic [1:0]  fetch_epoch;
    logic        kill;
    logic [31:0] redirect_cnt;
    logic [31:0] hold_cnt;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .RESET_PC (32'h0000_0000),
        .EPOCH_W  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bpu_next_pc     (bpu_next_pc),
        .bpu_jump        (bpu_jump),
        .exe_mispredict  (exe_mispredict),
        .exe_redirect_pc (exe_redirect_pc),
        .dc_mispredict   (dc_mispredict),
        .dc_redirect_pc  (dc_redirect_pc),
        .stall           (stall),
        .IM_ready        (IM_ready),
        .fetch_pc        (fetch_pc),
        .fetch_req       (fetch_req),
        .fetch_jump      (fetch_jump),
        .fetch_epoch     (fetch_epoch),
        .kill            (kill),
        .redirect_cnt    (redirect_cnt),
        .hold_cnt        (hold_cnt)
    );

    // ---------------- behavioural reference model ----------------
    // Described by what the front end is doing: still booting, parked on a
    // hold, or in the cycle right after a redirect.
    bit          m_booting, m_parked, m_redirected, m_jump;
    logic [31:0] m_pc;
    int          m_epoch;
    longint      m_rcnt, m_hcnt;

    task automatic model_step();
        if (rst) begin
            m_booting = 1; m_parked = 0; m_redirected = 0;
            m_pc = 32'h0; m_epoch = 0; m_jump = 0; m_rcnt = 0; m_hcnt = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else begin
            if (m_parked && m_hcnt < 64'hFFFF_FFFF) m_hcnt++;
            if (exe_mispredict || dc_mispredict) begin
                if (m_rcnt < 64'hFFFF_FFFF) m_rcnt++;
                m_pc = exe_mispredict ? exe_redirect_pc : dc_redirect_pc;
                m_epoch = (m_epoch + 1) % EPOCH_MOD;
                m_jump = 0; m_redirected = 1; m_parked = 0;
            end else if (stall || !IM_ready) begin
                m_parked = 1; m_redirected = 0;
            end else begin
                m_pc = bpu_next_pc; m_jump = bpu_jump;
                m_parked = 0; m_redirected = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // leave the outputs settled 1 time unit after the edge.
    task automatic apply(input logic r, input logic e, input logic [31:0] epc,
                         input logic d, input logic [31:0] dpc, input logic s,
                         input logic imr, input logic [31:0] bpc, input logic bj);
        rst = r; exe_mispredict = e; exe_redirect_pc = epc;
        dc_mispredict = d; dc_redirect_pc = dpc; stall = s; IM_ready = imr;
        bpu_next_pc = bpc; bpu_jump = bj;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic [31:0] bpc);
        apply(0, 0, 32'h0, 0, 32'h0, 0, 1, bpc, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, exe;  logic [31:0] exe_pc;
        logic        dc;        logic [31:0] dc_pc;
        logic        stall, imr; logic [31:0] bpu; logic bj;
        logic [31:0] e_pc; logic e_req, e_kill; logic [1:0] e_ep; logic e_jump;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic [31:0] epc, logic d,
                                logic [31:0] dpc, logic s, logic imr,
                                logic [31:0] bpc, logic bj, logic [31:0] xpc,
                                logic xreq, logic xkill, logic [1:0] xep, logic xj);
        vec_t v;
        v.rst = r; v.exe = e; v.exe_pc = epc; v.dc = d; v.dc_pc = dpc;
        v.stall = s; v.imr = imr; v.bpu = bpc; v.bj = bj;
        v.e_pc = xpc; v.e_req = xreq; v.e_kill = xkill; v.e_ep = xep; v.e_jump = xj;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected columns are the outputs right after that row's edge.
        //            rst exe exe_pc      dc dc_pc        st imr bpu         bj   pc         req kil ep jmp
        tbl.push_back(mk(1, 0, 32'h0,     0, 32'h0,       0, 1, 32'h4,    0,  32'h0,     0, 0, 0, 0)); // reset -> BOOT
        tbl.push_back(mk(0, 1, 32'h999,   1, 32'h888,     0, 1, 32'h4,    0,  32'h0,     1, 0, 0, 0)); // BOOT ignores redirects
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 1, 32'h4,    1,  32'h4,     1, 0, 0, 1)); // RUN follows BPU
        tbl.push_back(mk(0, 1, 32'h100,   1, 32'h200,     0, 1, 32'h8,    1,  32'h100,   1, 1, 1, 0)); // exe beats dc
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 1, 32'h20,   0,  32'h20,    1, 0, 1, 0)); // FLUSH -> RUN
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 0, 32'h40,   0,  32'h20,    0, 0, 1, 0)); // hold 1
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 0, 32'h40,   0,  32'h20,    0, 0, 1, 0)); // hold 2
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 0, 32'h40,   0,  32'h20,    0, 0, 1, 0)); // hold 3
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 1, 32'h40,   0,  32'h40,    1, 0, 1, 0)); // release
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       1, 1, 32'h44,   0,  32'h40,    0, 0, 1, 0)); // stall -> HOLD
        tbl.push_back(mk(0, 0, 32'h0,     1, 32'h80,      1, 1, 32'h44,   0,  32'h80,    1, 1, 2, 0)); // dc redirect in HOLD
        tbl.push_back(mk(0, 1, 32'h300,   0, 32'h0,       0, 1, 32'h44,   0,  32'h300,   1, 1, 3, 0)); // back-to-back
        tbl.push_back(mk(0, 0, 32'h0,     1, 32'h304,     0, 1, 32'h44,   0,  32'h304,   1, 1, 0, 0)); // epoch wraps
        tbl.push_back(mk(0, 1, 32'h308,   0, 32'h0,       0, 1, 32'h44,   0,  32'h308,   1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,     1, 32'h30C,     0, 1, 32'h44,   0,  32'h30C,   1, 1, 2, 0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 1, 32'h500,  1,  32'h500,   1, 0, 2, 1));
        tbl.push_back(mk(0, 1, 32'h600,   0, 32'h0,       0, 1, 32'h504,  1,  32'h600,   1, 1, 3, 0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       1, 1, 32'h604,  1,  32'h600,   0, 0, 3, 0)); // FLUSH -> HOLD
        tbl.push_back(mk(1, 1, 32'h700,   1, 32'h704,     0, 1, 32'h604,  1,  32'h0,     0, 0, 0, 0)); // reset beats redirect
        tbl.push_back(mk(0, 0, 32'h0,     0, 32'h0,       0, 1, 32'h8,    0,  32'h0,     1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'hFFFF_FFFC, 0, 32'h0,   0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 0, 1)); // top of space

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].exe, tbl[i].exe_pc, tbl[i].dc, tbl[i].dc_pc,
                  tbl[i].stall, tbl[i].imr, tbl[i].bpu, tbl[i].bj);
            chk($sformatf("tbl%0d.pc", i),    fetch_pc,           tbl[i].e_pc);
            chk($sformatf("tbl%0d.req", i),   {31'b0, fetch_req},  {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d.kill", i),  {31'b0, kill},       {31'b0, tbl[i].e_kill});
            chk($sformatf("tbl%0d.epoch", i), {30'b0, fetch_epoch}, {30'b0, tbl[i].e_ep});
            chk($sformatf("tbl%0d.jump", i),  {31'b0, fetch_jump}, {31'b0, tbl[i].e_jump});
        end

        // Epoch wrap from a clean reset: 1, 2, 3, 0 with kill after each.
        apply(1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0);
        idle(32'h0);
        for (int k = 0; k < 4; k++) begin
            apply(0, k[0], 32'h1000 + 32'(k), ~k[0], 32'h2000 + 32'(k), 0, 1, 32'h4, 0);
            chk($sformatf("wrap%0d.epoch", k), {30'b0, fetch_epoch}, 32'((k + 1) % 4));
            chk($sformatf("wrap%0d.kill", k), {31'b0, kill}, 32'd1);
            chk($sformatf("wrap%0d.pc", k), fetch_pc,
                k[0] ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k));
        end
        idle(32'h4);
        chk("wrap.kill_clear", {31'b0, kill}, 32'd0);

        // Perf counters: 5 redirects, then 7 HOLD cycles.
        apply(1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0);
        chk("perf.rst_rcnt", redirect_cnt, 32'd0);
        chk("perf.rst_hcnt", hold_cnt, 32'd0);
        idle(32'h0);
        for (int k = 0; k < 5; k++) apply(0, 1, 32'h40 * 32'(k + 1), 0, 32'h0, 0, 1, 32'h0, 0);
        idle(32'h10);
        for (int k = 0; k < 7; k++) apply(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h14, 0);
        idle(32'h14);
        chk("perf.redirect_cnt", redirect_cnt, PERF ? 32'd5 : 32'd0);
        chk("perf.hold_cnt", hold_cnt, PERF ? 32'd7 : 32'd0);

        // Randomized run against the model.
        apply(1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0);
        for (int c = 0; c < 2000; c++) begin
            apply(($urandom_range(63) == 0), ($urandom_range(7) == 0), $urandom,
                  ($urandom_range(7) == 0), $urandom, ($urandom_range(3) == 0),
                  ($urandom_range(3) != 0), $urandom, 1'($urandom));
            chk("rnd.pc", fetch_pc, m_pc);
            chk("rnd.req", {31'b0, fetch_req}, {31'b0, !m_booting && !m_parked});
            chk("rnd.kill", {31'b0, kill}, {31'b0, m_redirected});
            chk("rnd.epoch", {30'b0, fetch_epoch}, 32'(m_epoch));
            chk("rnd.jump", {31'b0, fetch_jump}, {31'b0, m_jump});
            chk("rnd.rcnt", redirect_cnt, PERF ? m_rcnt[31:0] : 32'd0);
            chk("rnd.hcnt", hold_cnt, PERF ? m_hcnt[31:0] : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_fetch_redirect_ctrl
